// File: rtl/bc_pkg.sv
// Shared definitions for the 2-bit comparator check harness and its reference.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package bc_pkg;

  localparam int VEC_W = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETTLE = ST_SETTLE,
    CHECK  = ST_CHECK,
    DONE   = ST_DONE
  } state_t;

  // Expected {c,d,e} for vector {b2,b1,a2,a1}; A={a1,a2}, B={b1,b2}, a1/b1 are MSBs.
  function automatic logic [2:0] bc_expect(input logic [VEC_W-1:0] vec);
    logic [1:0] a;
    logic [1:0] b;
    a = {vec[0], vec[1]};
    b = {vec[2], vec[3]};
    return {(a > b), (a == b), (a < b)};
  endfunction

endpackage

// File: rtl/bc_ref.sv
// Reference comparator: expected {c,d,e} for the stimulus currently driven.
// Latency: combinational.
// Backpressure: none.
import bc_pkg::*;

module bc_ref (
  input  logic       a1,
  input  logic       a2,
  input  logic       b1,
  input  logic       b2,
  output logic [2:0] cde
);

  assign cde = bc_expect({b2, b1, a2, a1});

endmodule

// File: rtl/bc_checker.sv
// Exhaustive self-check of the 2-bit comparator: drives 16 vectors, samples c,d,e.
// Latency: 16*(SETTLE_CYCLES+1) cycles from accepted start to done.
// Backpressure: none; start is ignored while a run is in progress.
import bc_pkg::*;

module bc_checker #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a1,
  output logic       a2,
  output logic       b1,
  output logic       b2,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic [3:0] fail_vec
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [VEC_W-1:0] vec;
  logic [3:0]       settle_cnt;
  logic [2:0]       exp_cde;
  logic             mismatch;
  logic [4:0]       err_next;

  // Reference is fed from the registered stimulus, so it tracks what the comparator sees.
  bc_ref u_ref (
    .a1  (a1),
    .a2  (a2),
    .b1  (b1),
    .b2  (b2),
    .cde (exp_cde)
  );

  // Any bit difference counts, so invalid codes (000, 110, ...) are mismatches too.
  assign mismatch = ({c, d, e} != exp_cde);
  assign err_next = err_cnt + {4'd0, mismatch};

  // Run sequencer: apply vector, wait SETTLE_CYCLES, check, advance; results held in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec        <= '0;
      settle_cnt <= '0;
      {b2, b1, a2, a1} <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_vec   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec        <= '0;
            settle_cnt <= '0;
            {b2, b1, a2, a1} <= '0;
            err_cnt    <= '0;
            fail_vec   <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 4'd1;
          if (settle_cnt == SETTLE_LAST) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          err_cnt <= err_next;
          // Only the first failure of a run is recorded.
          if (mismatch && (err_cnt == 5'd0)) begin
            fail_vec <= vec;
          end
          if (vec == 4'd15) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 5'd0);
            state <= DONE;
          end else begin
            vec        <= vec + 4'd1;
            {b2, b1, a2, a1} <= vec + 4'd1;
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
